// File: rtl/imm_rotation_encoder.sv
// Iterative encoder for rotated-immediate operands: finds the smallest even
// right-rotate (2*rot) and imm8 with ROR(imm8, 2*rot) == value, one candidate per clock.
module imm_rotation_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [3:0]  rot,
  output logic [7:0]  imm8,
  output logic [11:0] encoded
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // The upper half of {v,v} << sh is a left rotate without ever shifting by 32.
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] w;
    w = {v, v} << sh;
    return w[63:32];
  endfunction

  logic [1:0]  state_r, state_s;
  logic [3:0]  r_r, r_s;
  logic [31:0] v_q_r, v_q_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        valid_r, valid_s;
  logic [3:0]  rot_r, rot_s;
  logic [7:0]  imm8_r, imm8_s;
  logic [31:0] cand_s;
  logic        hit_s;

  assign cand_s = rol32(v_q_r, {r_r, 1'b0});
  assign hit_s  = (cand_s[31:8] == 24'd0);

  // Next-state and next-result computation for the search FSM.
  always_comb begin
    state_s = state_r;
    r_s     = r_r;
    v_q_s   = v_q_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    valid_s = valid_r;
    rot_s   = rot_r;
    imm8_s  = imm8_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SEARCH;
          r_s     = 4'd0;
          v_q_s   = value;
          busy_s  = 1'b1;
          valid_s = 1'b0;
          rot_s   = 4'd0;
          imm8_s  = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (hit_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          valid_s = 1'b1;
          rot_s   = r_r;
          imm8_s  = cand_s[7:0];
        end else if (r_r == 4'd15) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          valid_s = 1'b0;
          rot_s   = 4'd0;
          imm8_s  = 8'd0;
        end else begin
          r_s = r_r + 4'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and result registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      r_r     <= 4'd0;
      v_q_r   <= 32'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      rot_r   <= 4'd0;
      imm8_r  <= 8'd0;
    end else begin
      state_r <= state_s;
      r_r     <= r_s;
      v_q_r   <= v_q_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      valid_r <= valid_s;
      rot_r   <= rot_s;
      imm8_r  <= imm8_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign valid   = valid_r;
  assign rot     = rot_r;
  assign imm8    = imm8_r;
  assign encoded = {rot_r, imm8_r};

endmodule

// File: tb/tb_imm_rotation_encoder.sv
// Directed plus random checks of imm_rotation_encoder against a bit-level
// reference model, using a queue of expected results popped on each done pulse.
module tb_imm_rotation_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic [3:0]  rot;
  logic [7:0]  imm8;
  logic [11:0] encoded;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] val;
    logic        ok;
    logic [3:0]  rr;
    logic [7:0]  ii;
    int          lat;
  } exp_t;

  exp_t sb[$];

  imm_rotation_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .valid   (valid),
    .rot     (rot),
    .imm8    (imm8),
    .encoded (encoded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Right rotate of the zero-extended immediate, done bit by bit.
  function automatic logic [31:0] ror_dec(input logic [7:0] im, input int amt);
    logic [31:0] z;
    logic [31:0] d;
    z = {24'd0, im};
    for (int i = 0; i < 32; i++) d[i] = z[(i + amt) % 32];
    return d;
  endfunction

  // Scans rotations from the top down so the smallest fitting rot is kept last.
  function automatic void ref_encode(input logic [31:0] v, output logic ok,
                                     output logic [3:0] rr, output logic [7:0] ii);
    logic [7:0] im;
    ok = 1'b0;
    rr = 4'd0;
    ii = 8'd0;
    for (int r = 15; r >= 0; r--) begin
      for (int i = 0; i < 8; i++) im[i] = v[(i - 2 * r + 32) % 32];
      if (ror_dec(im, 2 * r) == v) begin
        ok = 1'b1;
        rr = 4'(r);
        ii = im;
      end
    end
  endfunction

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run_one(input logic [31:0] v, input bit noisy, input bit hold);
    exp_t e;
    exp_t got;
    int   n;
    bit   seen;
    e.val = v;
    ref_encode(v, e.ok, e.rr, e.ii);
    e.lat = e.ok ? int'(e.rr) + 2 : 17;
    sb.push_back(e);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    value = $urandom;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_accept", 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        if (!hold) start = 1'b0;
      end else if (noisy) begin
        start = 1'($urandom_range(0, 1));
        value = $urandom;
      end
    end
    got = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL timeout: no done for value 0x%0h", got.val);
      start = 1'b0;
    end else begin
      check("latency", 32'(n), 32'(got.lat));
      check("valid", 32'(valid), 32'(got.ok));
      check("rot", 32'(rot), 32'(got.rr));
      check("imm8", 32'(imm8), 32'(got.ii));
      check("encoded", 32'(encoded), {20'd0, got.rr, got.ii});
      if (valid) check("decode", ror_dec(imm8, 2 * int'(rot)), got.val);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_not_busy", 32'(busy), 32'd0);
      check("result_hold", 32'(encoded), {20'd0, got.rr, got.ii});
    end
  endtask

  initial begin
    logic [31:0] v;
    rst   = 1'b1;
    start = 1'b0;
    value = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_encoded", 32'(encoded), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_one(32'h0000_00AB, 1'b0, 1'b0);
    run_one(32'hFF00_0000, 1'b0, 1'b0);
    run_one(32'hF000_000F, 1'b0, 1'b0);
    run_one(32'h0000_0104, 1'b0, 1'b0);
    run_one(32'h0000_0102, 1'b0, 1'b0);
    run_one(32'h0000_0000, 1'b0, 1'b0);
    run_one(32'h0000_0104, 1'b1, 1'b0);
    run_one(32'hFF00_0000, 1'b0, 1'b1);
    run_one(32'h0000_00AB, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a failing search.
    start = 1'b1;
    value = 32'h0000_0102;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_rot", 32'(rot), 32'd0);
    check("midrst_imm8", 32'(imm8), 32'd0);
    check("midrst_encoded", 32'(encoded), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_one(32'h3FC0_0000, 1'b0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 1) == 1)
        v = ror_dec(8'($urandom), 2 * int'($urandom_range(0, 15)));
      else if ($urandom_range(0, 3) == 0)
        v = ror_dec(8'($urandom), int'($urandom_range(0, 31)));
      else
        v = $urandom;
      run_one(v, 1'b0, 1'b0);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
